// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with a bouncing square object select.
// All outputs are registered and change only on pixel-tick edges, except the one-clock frame_start pulse.

module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       sel
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit views so box edge + step never wraps during comparison
    localparam logic [10:0] HA_W      = 11'(H_ACTIVE);
    localparam logic [10:0] VA_W      = 11'(V_ACTIVE);
    localparam logic [10:0] BOX_W     = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] HS_FIRST  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  STEP_10   = 10'(STEP);

    logic [DIV_W-1:0] div;
    logic [9:0]       h;
    logic [9:0]       v;
    logic [9:0]       box_x;
    logic [9:0]       box_y;
    logic             dir_x;
    logic             dir_y;

    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             wrap;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic [9:0]       box_x_nxt;
    logic [9:0]       box_y_nxt;
    logic             dir_x_nxt;
    logic             dir_y_nxt;
    logic [10:0]      hn;
    logic [10:0]      vn;
    logic [10:0]      bxn;
    logic [10:0]      byn;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             video_on_nxt;
    logic             sel_nxt;

    always_comb begin
        tick   = (div == DIV_LAST);
        h_last = (h == H_LAST);
        v_last = (v == V_LAST);
        wrap   = tick && h_last && v_last;

        h_nxt = h_last ? 10'd0 : h + 10'd1;
        v_nxt = v;
        if (h_last) begin
            v_nxt = v_last ? 10'd0 : v + 10'd1;
        end
    end

    // Object reflects off the active-area edges; motion is evaluated once per frame wrap
    always_comb begin
        box_x_nxt = box_x;
        box_y_nxt = box_y;
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        if (wrap && en) begin
            if (dir_x) begin
                if ({1'b0, box_x} + BOX_W + STEP_W > HA_W) begin
                    dir_x_nxt = 1'b0;
                    box_x_nxt = box_x - STEP_10;
                end else begin
                    box_x_nxt = box_x + STEP_10;
                end
            end else if ({1'b0, box_x} < STEP_W) begin
                dir_x_nxt = 1'b1;
                box_x_nxt = box_x + STEP_10;
            end else begin
                box_x_nxt = box_x - STEP_10;
            end

            if (dir_y) begin
                if ({1'b0, box_y} + BOX_W + STEP_W > VA_W) begin
                    dir_y_nxt = 1'b0;
                    box_y_nxt = box_y - STEP_10;
                end else begin
                    box_y_nxt = box_y + STEP_10;
                end
            end else if ({1'b0, box_y} < STEP_W) begin
                dir_y_nxt = 1'b1;
                box_y_nxt = box_y + STEP_10;
            end else begin
                box_y_nxt = box_y - STEP_10;
            end
        end
    end

    // Output decode uses post-increment position and post-move box so pixel (0,0) sees the new frame
    always_comb begin
        hn  = {1'b0, h_nxt};
        vn  = {1'b0, v_nxt};
        bxn = {1'b0, box_x_nxt};
        byn = {1'b0, box_y_nxt};

        hsync_nxt    = !((hn >= HS_FIRST) && (hn <= HS_LAST));
        vsync_nxt    = !((vn >= VS_FIRST) && (vn <= VS_LAST));
        video_on_nxt = (hn < HA_W) && (vn < VA_W);
        sel_nxt      = video_on_nxt
                    && (hn >= bxn) && (hn <= bxn + BOX_W - 11'd1)
                    && (vn >= byn) && (vn <= byn + BOX_W - 11'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            box_x       <= '0;
            box_y       <= '0;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            sel         <= 1'b0;
            frame_start <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
        end else begin
            div         <= tick ? '0 : div + 1'b1;
            frame_start <= wrap;
            box_x       <= box_x_nxt;
            box_y       <= box_y_nxt;
            dir_x       <= dir_x_nxt;
            dir_y       <= dir_y_nxt;
            if (tick) begin
                h        <= h_nxt;
                v        <= v_nxt;
                pixel_x  <= h_nxt;
                pixel_y  <= v_nxt;
                hsync    <= hsync_nxt;
                vsync    <= vsync_nxt;
                video_on <= video_on_nxt;
                sel      <= sel_nxt;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the system clock: hsync, vsync, video_on and pixel coordinates.
- Also generates the per-pixel select bit that drives the downstream 2:1 colour mux. The mux chooses between background colour (s=0) and object colour (s=1).
- The object is a square that bounces around the active area, moving once per frame.
- Sits directly upstream of the colour mux and the VGA output pins.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (100 MHz -> 25 MHz); must be >= 1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- BOX_SIZE, 32, object edge length in pixels.
- STEP, 2, object displacement per frame per axis in pixels.
- Constraints: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP <= 1024; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP <= 1024; BOX_SIZE+STEP <= H_ACTIVE and <= V_ACTIVE.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high.
- en, input, 1, object motion enable; sampled at frame wrap.
- hsync, output, 1, horizontal sync, active low.
- vsync, output, 1, vertical sync, active low.
- video_on, output, 1, high while the current pixel is in the active area.
- pixel_x, output, 10, current column (h counter).
- pixel_y, output, 10, current line (v counter).
- frame_start, output, 1, one-clk pulse on frame wrap.
- sel, output, 1, drives the mux select; 1 = object pixel.

Behaviour:
- Reset is synchronous and active-high. While reset=1 at a clk edge:
  - div counter, h, v, box_x and box_y go to 0; dir_x and dir_y go to + (increasing).
  - Output values: hsync=1, vsync=1, video_on=0, sel=0, frame_start=0, pixel_x=0, pixel_y=0.
  - Reset mid-frame aborts the frame immediately; no partial pulses follow.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps to 0.
  - tick=1 in the cycle where div==CLK_DIV-1. With CLK_DIV=1, tick is every cycle.
- Counters (advance only on tick):
  - h increments; on h==H_TOTAL-1, h goes to 0 and v increments.
  - On v==V_TOTAL-1 with h wrapping, v goes to 0: this is the frame wrap.
- Registered outputs:
  - All outputs are registers, updated only on tick edges. They hold their value between ticks.
  - Each update reflects the new (post-increment) h/v values: pixel_x=h, pixel_y=v.
  - hsync=0 iff H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1.
  - vsync=0 iff V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1.
  - video_on=1 iff h<H_ACTIVE and v<V_ACTIVE.
  - sel=1 iff video_on and box_x <= h <= box_x+BOX_SIZE-1 and box_y <= v <= box_y+BOX_SIZE-1; otherwise 0.
  - Consequence: outputs keep their reset values until the first tick, so pixel (0,0) of the first frame after reset is blanked.
- frame_start:
  - 1 for exactly one clk, on the tick edge where (h,v) wraps to (0,0); 0 otherwise.
- Object motion:
  - Evaluated only at frame wrap, and only if en=1; if en=0, box and dir hold.
  - X axis, dir_x=+:
    - if box_x+BOX_SIZE+STEP > H_ACTIVE, then dir_x becomes - and box_x becomes box_x-STEP;
    - else box_x becomes box_x+STEP.
  - X axis, dir_x=-:
    - if box_x < STEP, then dir_x becomes + and box_x becomes box_x+STEP;
    - else box_x becomes box_x-STEP.
  - Y axis: identical rule using box_y, dir_y and V_ACTIVE.
  - The sel value registered on the wrap edge (pixel 0,0) is computed from the updated box position. The new position therefore applies to the whole new frame.
- Arithmetic:
  - Comparisons use at least 11 bits so that box_x+BOX_SIZE+STEP cannot overflow.
  - box_x and box_y never leave [0, H_ACTIVE-BOX_SIZE] and [0, V_ACTIVE-BOX_SIZE] respectively.
- Latency: none beyond the output register. There is no handshake; downstream samples outputs on every clk.

Test Plan:
- Reset then idle (defaults):
  - Ticks occur on the 4th, 8th, ... clk after reset deassert.
  - After the 1st tick: pixel_x=1, video_on=1, hsync=1.
  - Outputs never change between ticks.
- Line timing (defaults):
  - hsync goes 0 when pixel_x becomes 656 and returns to 1 when pixel_x becomes 752.
  - video_on goes 0 at pixel_x=640.
  - pixel_x wraps 799->0 with pixel_y incrementing.
- Frame timing (defaults):
  - vsync is low for exactly lines 490..491 (2x800 ticks).
  - frame_start pulses once every 1,680,000 clks, width 1 clk.
- Object (defaults, en=1):
  - Frame 0: sel=1 for x,y in 0..31 only.
  - After 1st wrap: box_x=box_y=2, so sel=1 for x,y in 2..33.
  - en=0 across a wrap: box position unchanged.
- Bounce (override H_ACTIVE=64, BOX_SIZE=32, STEP=16):
  - box_x over successive wraps must be 0, 16, 32, 16, 0, 16.
- Reset mid-frame (assert at pixel_y=200):
  - Next clk: all outputs take their reset values, box returns to (0,0).
  - After release: the frame restarts from h=v=0.
